// File: rtl/vec_mul_sequencer.sv
// vec_mul_sequencer: control FSM running one matrix-vector job on the vec_mul datapath
module vec_mul_sequencer #(
  parameter int ADDRESSSIZE = 10,
  parameter int ADDRESSSIZE_fifo = 2,
  parameter int PIPE_LATENCY = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        abort,
  input  logic [ADDRESSSIZE-1:0]      cfg_ub_base,
  input  logic [ADDRESSSIZE-1:0]      cfg_res_base,
  input  logic [ADDRESSSIZE:0]        cfg_num_vecs,
  input  logic [ADDRESSSIZE_fifo-1:0] cfg_weight_sel,
  output logic [ADDRESSSIZE_fifo-1:0] weight_address,
  output logic                        weight_reload,
  output logic [ADDRESSSIZE-1:0]      ub_address,
  output logic                        ub_read_en,
  output logic                        res_write_enable,
  output logic [ADDRESSSIZE-1:0]      res_address,
  output logic                        busy,
  output logic                        done,
  output logic [ADDRESSSIZE:0]        vec_count
);
  typedef enum logic [2:0] {IDLE, WADDR, WLOAD, STREAM, DRAIN, DONE} state_t;
  localparam logic [ADDRESSSIZE:0]   one_n = 1;
  localparam logic [ADDRESSSIZE-1:0] one_a = 1;
  state_t state, nxt;
  logic [PIPE_LATENCY-1:0] vld;
  logic [ADDRESSSIZE:0] num, left;
  logic accept, kill;
  assign accept = state == IDLE && start && !abort;
  assign kill = state != IDLE && abort;
  assign res_write_enable = vld[PIPE_LATENCY-1];
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = cfg_num_vecs == '0 ? DONE : WADDR;
      WADDR:   nxt = WLOAD;
      WLOAD:   nxt = STREAM;
      STREAM:  if (left == one_n) nxt = DRAIN;
      // the line shifts once more before the next state is seen, so look one stage early
      DRAIN:   if (vld[PIPE_LATENCY-2:0] == '0) nxt = DONE;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      vld <= '0;
      num <= '0;
      left <= '0;
      weight_address <= '0;
      weight_reload <= 1'b0;
      ub_address <= '0;
      ub_read_en <= 1'b0;
      res_address <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      vec_count <= '0;
    end else begin
      state <= nxt;
      vld <= kill ? '0 : {vld[PIPE_LATENCY-2:0], ub_read_en};
      weight_reload <= nxt == WLOAD;
      ub_read_en <= nxt == STREAM;
      busy <= nxt inside {WADDR, WLOAD, STREAM, DRAIN};
      done <= nxt == DONE;
      if (accept) begin
        num <= cfg_num_vecs;
        left <= cfg_num_vecs;
        weight_address <= cfg_weight_sel;
        ub_address <= cfg_ub_base;
        res_address <= cfg_res_base;
        vec_count <= '0;
      end else begin
        if (state == STREAM) begin
          left <= left - one_n;
          ub_address <= ub_address + one_a;
        end
        if (res_write_enable) begin
          res_address <= res_address + one_a;
          if (vec_count != num) vec_count <= vec_count + one_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_vec_mul_sequencer.sv
// tb_vec_mul_sequencer: randomized and directed jobs checked against a cycle-timeline model
module tb_vec_mul_sequencer;
  localparam int AW = 10;
  localparam int FW = 2;
  localparam int L = 16;
  localparam int NO_ABORT = 1000000;
  logic clk = 1'b0;
  logic rstn, start, abort;
  logic [AW-1:0] cfg_ub_base, cfg_res_base;
  logic [AW:0] cfg_num_vecs;
  logic [FW-1:0] cfg_weight_sel;
  logic [FW-1:0] weight_address;
  logic weight_reload, ub_read_en, res_write_enable, busy, done;
  logic [AW-1:0] ub_address, res_address;
  logic [AW:0] vec_count;
  int passed = 0;
  int total = 0;

  vec_mul_sequencer #(.ADDRESSSIZE(AW), .ADDRESSSIZE_fifo(FW), .PIPE_LATENCY(L)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_ub_base(cfg_ub_base), .cfg_res_base(cfg_res_base),
    .cfg_num_vecs(cfg_num_vecs), .cfg_weight_sel(cfg_weight_sel),
    .weight_address(weight_address), .weight_reload(weight_reload),
    .ub_address(ub_address), .ub_read_en(ub_read_en),
    .res_write_enable(res_write_enable), .res_address(res_address),
    .busy(busy), .done(done), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  // Cycle c is the period ending at edge c; start is sampled at edge 0 and
  // abort (when used) is high during cycle abort_c, taking effect from cycle abort_c+1.
  task automatic run_job(input logic [AW-1:0] ub, input logic [AW-1:0] res, input int n,
                         input logic [FW-1:0] sel, input int abort_c, input int extra_c,
                         input bit chain);
    int done_c, last_c, writes;
    bit act, e_rd, e_wl, e_wr, e_busy, e_done;
    logic [AW-1:0] e_addr;
    logic [4:0] e_ctl, a_ctl;
    done_c = n == 0 ? 1 : n + 3 + L;
    last_c = chain ? done_c : (abort_c < done_c ? abort_c + 1 : done_c) + 2;
    writes = 0;
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      if (c > 0) begin
        act = c <= abort_c;
        e_rd = act && n > 0 && c >= 3 && c <= n + 2;
        e_wl = act && n > 0 && c == 2;
        e_wr = act && n > 0 && c >= 3 + L && c <= n + 2 + L;
        e_busy = act && n > 0 && c <= n + 2 + L;
        e_done = act && c == done_c;
        e_ctl = {e_wl, e_rd, e_wr, e_busy, e_done};
        a_ctl = {weight_reload, ub_read_en, res_write_enable, busy, done};
        total++;
        if (a_ctl !== e_ctl) $display("FAIL ctl cycle %0d n=%0d: {wl,rd,wr,busy,done} got %b want %b", c, n, a_ctl, e_ctl);
        else passed++;
        if (e_rd) begin
          e_addr = ub + AW'(c - 3);
          total++;
          if (ub_address !== e_addr) $display("FAIL ub_address cycle %0d: got %h want %h", c, ub_address, e_addr);
          else passed++;
        end
        if (e_wr) begin
          e_addr = res + AW'(c - 3 - L);
          total++;
          if (res_address !== e_addr) $display("FAIL res_address cycle %0d: got %h want %h", c, res_address, e_addr);
          else passed++;
        end
        if (act && n > 0 && c <= 2) begin
          total++;
          if (weight_address !== sel) $display("FAIL weight_address cycle %0d: got %0d want %0d", c, weight_address, sel);
          else passed++;
        end
        total++;
        if (vec_count !== (AW + 1)'(writes)) $display("FAIL vec_count cycle %0d: got %0d want %0d", c, vec_count, writes);
        else passed++;
        if (e_wr) writes++;
      end
      cfg_ub_base = ub;
      cfg_res_base = res;
      cfg_num_vecs = (AW + 1)'(n);
      cfg_weight_sel = sel;
      start = c == 0 || c == extra_c;
      abort = c == abort_c;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    cfg_ub_base = '1;
    cfg_res_base = '1;
    cfg_num_vecs = 11'd5;
    cfg_weight_sel = '1;
    repeat (3) @(negedge clk);
    total++;
    if ({weight_address, weight_reload, ub_address, ub_read_en, res_write_enable, res_address, busy, done, vec_count} !== '0)
      $display("FAIL reset outputs: wa=%0d wl=%b ub=%h rd=%b wr=%b ra=%h busy=%b done=%b vc=%0d",
               weight_address, weight_reload, ub_address, ub_read_en, res_write_enable, res_address, busy, done, vec_count);
    else passed++;
    start = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_job(10'h010, 10'h000, 4, 2'd2, NO_ABORT, -1, 1'b0);
  endtask

  task automatic test_wrap();
    run_job(10'h3FE, 10'h3FF, 3, 2'd1, NO_ABORT, -1, 1'b0);
  endtask

  task automatic test_zero_length();
    run_job(10'h123, 10'h045, 0, 2'd3, NO_ABORT, -1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_job(10'h020, 10'h100, 4, 2'd0, NO_ABORT, 5, 1'b1);
    run_job(10'h030, 10'h200, 2, 2'd3, NO_ABORT, -1, 1'b0);
  endtask

  task automatic test_abort_drain();
    run_job(10'h040, 10'h050, 8, 2'd1, 20, -1, 1'b0);
    total++;
    if (vec_count !== 11'd2) $display("FAIL abort vec_count: got %0d want 2", vec_count);
    else passed++;
  endtask

  task automatic test_abort_start_idle();
    logic [AW:0] held;
    held = vec_count;
    @(negedge clk);
    cfg_num_vecs = 11'd3;
    start = 1'b1;
    abort = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      total++;
      if ({busy, done, ub_read_en, weight_reload} !== 4'b0 || vec_count !== held)
        $display("FAIL abort_start_idle cycle %0d: busy=%b done=%b rd=%b wl=%b vc=%0d want vc=%0d", c, busy, done, ub_read_en, weight_reload, vec_count, held);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_stream();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c >= 5) begin
        total++;
        if ({weight_address, weight_reload, ub_address, ub_read_en, res_write_enable, res_address, busy, done, vec_count} !== '0)
          $display("FAIL reset_mid_stream cycle %0d: wl=%b rd=%b wr=%b busy=%b done=%b vc=%0d ub=%h ra=%h",
                   c, weight_reload, ub_read_en, res_write_enable, busy, done, vec_count, ub_address, res_address);
        else passed++;
      end
      cfg_ub_base = 10'h0AA;
      cfg_res_base = 10'h0BB;
      cfg_num_vecs = 11'd6;
      cfg_weight_sel = 2'd2;
      start = c == 0;
      rstn = !(c == 4);
    end
    rstn = 1'b1;
    for (int c = 0; c < L + 4; c++) begin
      @(negedge clk);
      total++;
      if (res_write_enable !== 1'b0 || done !== 1'b0) $display("FAIL reset_mid_stream late write/done: wr=%b done=%b", res_write_enable, done);
      else passed++;
    end
    run_job(10'h0AA, 10'h0BB, 6, 2'd2, NO_ABORT, -1, 1'b0);
  endtask

  task automatic test_random();
    int n, a;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, 24);
      a = $urandom_range(0, 1) ? int'($urandom_range(1, n + L + 4)) : NO_ABORT;
      run_job(AW'($urandom), AW'($urandom), n, FW'($urandom), a, -1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_length();
    test_start_while_busy();
    test_abort_drain();
    test_abort_start_idle();
    test_reset_mid_stream();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
